// File: rtl/kth_largest_pkg.sv
// Shared types and helpers for the K-largest rank tracker.
// Default-width layouts live here; the top re-derives widths from its own parameters.
package kth_largest_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_K          = 4;
    localparam int MAX_K          = 16;
    localparam int IDX_W          = $clog2(MAX_K + 1);
    localparam int DEF_COUNT_W    = $clog2(DEF_K + 1);
    localparam int DEF_SEL_W      = $clog2(DEF_K);

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] value;
        logic                      occupied;
    } slot_t;

    // Lowest set bit of the comparator row; MAX_K means the sample beats no slot.
    function automatic logic [IDX_W-1:0] first_beaten(input logic [MAX_K-1:0] beats);
        first_beaten = IDX_W'(MAX_K);
        for (int i = MAX_K - 1; i >= 0; i--) begin
            if (beats[i]) first_beaten = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/kth_slot_cell.sv
// One slot of the sorted list: hold, take din, take the upstream neighbour, or flush.
module kth_slot_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] up_value,
    input  logic                  up_occupied,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  occupied
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value    <= '0;
            occupied <= 1'b0;
        end else if (clr) begin
            value    <= '0;
            occupied <= 1'b0;
        end else if (load) begin
            value    <= din;
            occupied <= 1'b1;
        end else if (shift) begin
            value    <= up_value;
            occupied <= up_occupied;
        end
    end

endmodule

// File: rtl/kth_largest_tracker.sv
// Streaming tracker of the K largest samples with a combinational rank read port.
// Optional macro KTH_UNIQUE_EN: samples equal to a stored value are dropped.
module kth_largest_tracker
    import kth_largest_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int K          = DEF_K
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    din_valid,
    input  logic                    clear,
    input  logic [$clog2(K)-1:0]    rank_sel,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic [$clog2(K+1)-1:0]  count,
    output logic                    full
);

    localparam int CNT_W = $clog2(K + 1);
    localparam logic [IDX_W-1:0] IDX_K = IDX_W'(K);

    logic [DATA_WIDTH-1:0] value    [K];
    logic [DATA_WIDTH-1:0] up_value [K];
    logic [K-1:0]          occupied;
    logic [K-1:0]          up_occ;
    logic [K-1:0]          beats;
    logic [MAX_K-1:0]      beats_pad;
    logic [IDX_W-1:0]      ins_idx;
    logic                  dup;
    logic                  accept;

    // An empty slot loses to anything, so the sample lands in the first free slot at worst.
    for (genvar j = 0; j < K; j++) begin : g_cmp
        assign beats[j] = !occupied[j] || (value[j] < din);
    end

`ifdef KTH_UNIQUE_EN
    logic [K-1:0] equal;
    for (genvar j = 0; j < K; j++) begin : g_eq
        assign equal[j] = occupied[j] && (value[j] == din);
    end
    assign dup = |equal;
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        beats_pad        = '0;
        beats_pad[K-1:0] = beats;
    end

    assign ins_idx = first_beaten(beats_pad);
    assign accept  = din_valid && !clear && !dup && (ins_idx < IDX_K);

    for (genvar j = 0; j < K; j++) begin : g_slot
        if (j == 0) begin : g_head
            assign up_value[j] = '0;
            assign up_occ[j]   = 1'b0;
        end else begin : g_body
            assign up_value[j] = value[j-1];
            assign up_occ[j]   = occupied[j-1];
        end

        kth_slot_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
            .clk         (clk),
            .rst         (rst),
            .clr         (clear),
            .load        (accept && (ins_idx == IDX_W'(j))),
            .shift       (accept && (ins_idx <  IDX_W'(j))),
            .din         (din),
            .up_value    (up_value[j]),
            .up_occupied (up_occ[j]),
            .value       (value[j]),
            .occupied    (occupied[j])
        );
    end

    // Any accepted sample below capacity occupies exactly one more slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (accept && (count < CNT_W'(K))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign full = (count == CNT_W'(K));

    always_comb begin
        dout       = '0;
        dout_valid = 1'b0;
        if (int'(rank_sel) < K) begin
            dout       = value[rank_sel];
            dout_valid = occupied[rank_sel];
        end
    end

endmodule

// File: tb/tb_kth_largest_tracker.sv
// Self-checking bench for kth_largest_tracker at K=4, 8-bit samples.
module tb_kth_largest_tracker;

    localparam int W = 8;
    localparam int K = 4;

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_PUSH  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    typedef struct packed {
        logic [1:0]        op;
        logic [W-1:0]      din;
        logic [K-1:0][W-1:0] exp;
        logic [2:0]        cnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         clear = 1'b0;
    logic [1:0]   rank_sel = '0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic [2:0]   count;
    logic         full;

    int checks = 0;
    int errors = 0;
    int model[$];

    kth_largest_tracker #(.DATA_WIDTH(W), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .clear      (clear),
        .rank_sel   (rank_sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] op, input int d,
                                input int r0, input int r1, input int r2, input int r3,
                                input int cnt);
        vec_t v;
        v.op  = op;
        v.din = W'(d);
        v.exp = {W'(r3), W'(r2), W'(r1), W'(r0)};
        v.cnt = 3'(cnt);
        return v;
    endfunction

    task automatic cmp(input string tag, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, req);
        end
    endtask

    // Walks every rank through the combinational read port.
    task automatic check_state(input string tag, input logic [K-1:0][W-1:0] exp, input int cnt);
        for (int r = 0; r < K; r++) begin
            rank_sel = 2'(r);
            #1;
            cmp($sformatf("%s rank%0d valid", tag, r), int'(dout_valid), (r < cnt) ? 1 : 0);
            cmp($sformatf("%s rank%0d value", tag, r), int'(dout), (r < cnt) ? int'(exp[r]) : 0);
        end
        cmp({tag, " count"}, int'(count), cnt);
        cmp({tag, " full"}, int'(full), (cnt == K) ? 1 : 0);
        rank_sel = '0;
    endtask

    task automatic step(input logic [1:0] op, input logic [W-1:0] d);
        @(negedge clk);
        din       = d;
        din_valid = (op != OP_IDLE);
        clear     = (op == OP_CLEAR);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clear     = 1'b0;
    endtask

    function automatic void model_push(input int d);
`ifdef KTH_UNIQUE_EN
        foreach (model[i]) if (model[i] == d) return;
`endif
        model.push_back(d);
        model.rsort();
        if (model.size() > K) void'(model.pop_back());
    endfunction

    function automatic logic [K-1:0][W-1:0] model_vec();
        logic [K-1:0][W-1:0] v = '0;
        for (int r = 0; r < model.size(); r++) v[r] = W'(model[r]);
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk(OP_PUSH, 10, 10, 0, 0, 0, 1));
        vecs.push_back(mk(OP_PUSH, 40, 40, 10, 0, 0, 2));
        vecs.push_back(mk(OP_PUSH, 20, 40, 20, 10, 0, 3));
        vecs.push_back(mk(OP_PUSH, 30, 40, 30, 20, 10, 4));
        vecs.push_back(mk(OP_PUSH, 25, 40, 30, 25, 20, 4));
        vecs.push_back(mk(OP_PUSH, 5, 40, 30, 25, 20, 4));
        vecs.push_back(mk(OP_CLEAR, 200, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_PUSH, 7, 7, 0, 0, 0, 1));
`ifdef KTH_UNIQUE_EN
        vecs.push_back(mk(OP_PUSH, 7, 7, 0, 0, 0, 1));
        vecs.push_back(mk(OP_PUSH, 3, 7, 3, 0, 0, 2));
`else
        vecs.push_back(mk(OP_PUSH, 7, 7, 7, 0, 0, 2));
        vecs.push_back(mk(OP_PUSH, 3, 7, 7, 3, 0, 3));
`endif
        vecs.push_back(mk(OP_CLEAR, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(OP_PUSH, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_IDLE, 99, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_PUSH, 255, 255, 0, 0, 0, 2));
        vecs.push_back(mk(OP_PUSH, 255, 255, 255, 0, 0, 3));

        #12;
        check_state("reset", '0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].op, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].exp, int'(vecs[i].cnt));
        end

        // Fill, then pull reset between edges and expect an immediate drop.
        step(OP_CLEAR, 0);
        for (int v = 1; v <= K; v++) step(OP_PUSH, W'(v * 11));
        check_state("prefill", {8'd11, 8'd22, 8'd33, 8'd44}, 4);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", '0, 0);
        @(negedge clk);
        rst = 1'b0;
        step(OP_PUSH, 9);
        check_state("refill", {8'd0, 8'd0, 8'd0, 8'd9}, 1);

        model.delete();
        model.push_back(9);
        for (int n = 0; n < 300; n++) begin
            int pick = $urandom_range(0, 99);
            int d    = (pick < 70) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            if (pick < 4) begin
                step(OP_CLEAR, W'(d));
                model.delete();
            end else if (pick < 80) begin
                step(OP_PUSH, W'(d));
                model_push(d);
            end else begin
                step(OP_IDLE, W'(d));
            end
            check_state($sformatf("rnd%0d", n), model_vec(), model.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
